// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the IF/MEM pipeline stages
// and a single 8-bit synchronous RAM port.
//   - MEM requests take priority over IF; every access is split into 1, 2
//     or 4 byte cycles, little-endian.
//   - Read data returns one cycle after its address; the done pulse and
//     the assembled word appear together, one cycle after the last byte.
//   - stall_if / stall_mem are combinational: req & ~done.
// Optional build macro: MEMCTRL_IO_WAIT_EN. When it is defined, a store to
// the I/O region (addr[IO_ADDR_BIT:IO_ADDR_BIT-1] == 2'b11) holds off its
// write cycles while io_full is high. Otherwise io_full is ignored.
// Ports:
//   clk, rst           clock (rising edge), async active-low reset
//   if_req/if_addr     fetch request (always 4 bytes)
//   if_data/if_done    fetch result and one-cycle completion pulse
//   mem_req/we/len/addr/wdata   load/store request
//   mem_rdata/mem_done load result (zero-extended) and completion pulse
//   ram_din/ram_dout/ram_a/ram_wr   byte-wide RAM port
//   io_full            I/O write buffer full
//   stall_if/stall_mem stall requests to the pipeline stall controller
module mem_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned IO_ADDR_BIT = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_full,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [1:0]        cap_idx;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              owner_q, owner_d;   // 1 = MEM owns the access
  logic [ADDR_W-1:0] ram_a_d;
  logic [7:0]        ram_dout_d;
  logic              ram_wr_d;
  logic              if_done_d, mem_done_d;
  logic [31:0]       if_data_d, mem_rdata_d;
  logic              grant_io_hold, write_io_hold;

  // Request length code to byte count; 11 is a word.
  function automatic logic [CNT_W-1:0] len_of(input logic [1:0] code);
    case (code)
      2'b00:   len_of = CNT_W'(1);
      2'b01:   len_of = CNT_W'(2);
      default: len_of = CNT_W'(4);
    endcase
  endfunction

  // Byte idx of a word, little-endian.
  function automatic logic [7:0] byte_of(input logic [DATA_W-1:0] w, input logic [1:0] idx);
    byte_of = w[{idx, 3'b000} +: 8];
  endfunction

`ifdef MEMCTRL_IO_WAIT_EN
  logic io_q, io_d;   // current store targets the I/O region

  function automatic logic in_io(input logic [ADDR_W-1:0] a);
    in_io = (a[IO_ADDR_BIT -: 2] == 2'b11);
  endfunction

  assign grant_io_hold = io_full & in_io(mem_addr);
  assign write_io_hold = io_full & io_q;
`else
  logic unused_io;
  assign unused_io     = io_full;
  assign grant_io_hold = 1'b0;
  assign write_io_hold = 1'b0;
`endif

  // Stall requests follow the request directly so the pipeline freezes in the request cycle.
  assign stall_if  = if_req  & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    res_d       = res_q;
    owner_d     = owner_q;
    ram_a_d     = ram_a;
    ram_dout_d  = ram_dout;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data;
    mem_rdata_d = mem_rdata;
    cnt_inc     = cnt_q + CNT_W'(1);
    cap_idx     = 2'(cnt_q - CNT_W'(1));
`ifdef MEMCTRL_IO_WAIT_EN
    io_d        = io_q;
`endif

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          owner_d = 1'b1;
          addr_d  = mem_addr;
          len_d   = len_of(mem_len);
          wdata_d = mem_wdata;
          res_d   = '0;
          cnt_d   = '0;
          ram_a_d = mem_addr;
`ifdef MEMCTRL_IO_WAIT_EN
          io_d    = in_io(mem_addr);
`endif
          if (mem_we) begin
            state_d    = WRITE;
            ram_dout_d = mem_wdata[7:0];
            ram_wr_d   = ~grant_io_hold;
          end else begin
            state_d = READ;
          end
        end else if (if_req) begin
          owner_d = 1'b0;
          addr_d  = if_addr;
          len_d   = CNT_W'(4);
          res_d   = '0;
          cnt_d   = '0;
          ram_a_d = if_addr;
          state_d = READ;
        end
      end

      // cnt_q = cycles since grant; the byte in ram_din belongs to issue cnt_q-1.
      READ: begin
        if (cnt_q != '0) begin
          res_d[{cap_idx, 3'b000} +: 8] = ram_din;
        end
        if (cnt_q == len_q) begin
          state_d = DONE;
          if (owner_q) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = res_d;
          end else begin
            if_done_d = 1'b1;
            if_data_d = res_d;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc < len_q) begin
            ram_a_d = addr_q + ADDR_W'(cnt_inc);
          end
        end
      end

      // ram_wr high means byte cnt_q is being written this cycle; low means it is still pending.
      WRITE: begin
        if (ram_wr && (cnt_inc == len_q)) begin
          state_d    = DONE;
          mem_done_d = 1'b1;
        end else begin
          if (ram_wr) begin
            cnt_d = cnt_inc;
          end
          if (!write_io_hold) begin
            ram_wr_d   = 1'b1;
            ram_a_d    = addr_q + ADDR_W'(cnt_d);
            ram_dout_d = byte_of(wdata_q, cnt_d[1:0]);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      res_q     <= '0;
      owner_q   <= 1'b0;
      ram_a     <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_data   <= '0;
      mem_rdata <= '0;
`ifdef MEMCTRL_IO_WAIT_EN
      io_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      res_q     <= res_d;
      owner_q   <= owner_d;
      ram_a     <= ram_a_d;
      ram_dout  <= ram_dout_d;
      ram_wr    <= ram_wr_d;
      if_done   <= if_done_d;
      mem_done  <= mem_done_d;
      if_data   <= if_data_d;
      mem_rdata <= mem_rdata_d;
`ifdef MEMCTRL_IO_WAIT_EN
      io_q      <= io_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl with a byte-wide RAM model.
// Expected results come from the access rules: n bytes at addr+k,
// little-endian, read done n+1 cycles after grant, write done n cycles after.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_full;
  logic        stall_if;
  logic        stall_mem;

  int n_checks = 0;
  int n_fail   = 0;

  mem_ctrl #(.ADDR_W(32), .IO_ADDR_BIT(17)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .io_full(io_full), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sparse byte RAM with one-cycle read latency and a log of every write.
  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  bit [7:0] ram [bit [31:0]];
  wr_t      wr_log[$];

  always @(posedge clk) begin
    if (!$isunknown(ram_a)) begin
      ram_din <= ram.exists(ram_a) ? ram[ram_a] : 8'h00;
      if (ram_wr === 1'b1) begin
        wr_t e;
        e.a = ram_a;
        e.d = ram_dout;
        ram[ram_a] = ram_dout;
        wr_log.push_back(e);
      end
    end
  end

  // Observations of the last run_access call.
  int          obs_done;
  logic [31:0] obs_data;
  logic [31:0] obs_a[$];
  logic        obs_wr[$];
  int          obs_stall_bad;
  int          obs_other;

  function automatic int n_of(input bit is_mem, input logic [1:0] len);
    if (!is_mem) return 4;
    if (len == 2'b00) return 1;
    if (len == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] addr, input int n);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] ak = addr + 32'(k);
      v = v | (32'(ram.exists(ak) ? ram[ak] : 8'h00) << (8 * k));
    end
    return v;
  endfunction

  // Drive one request and record what happens until its done pulse.
  task automatic run_access(input bit is_mem, input bit we, input logic [1:0] len,
                            input logic [31:0] addr, input logic [31:0] wdata);
    obs_done = -1;
    obs_data = 32'h0;
    obs_a.delete();
    obs_wr.delete();
    obs_stall_bad = 0;
    obs_other = 0;
    wr_log.delete();
    @(negedge clk);
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      obs_a.push_back(ram_a);
      obs_wr.push_back(ram_wr);
      if (stall_if !== (if_req & ~if_done) || stall_mem !== (mem_req & ~mem_done)) obs_stall_bad++;
      if (is_mem ? if_done : mem_done) obs_other++;
      if (is_mem ? mem_done : if_done) begin
        obs_done = c;
        obs_data = is_mem ? mem_rdata : if_data;
        break;
      end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [108:0] all_out;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    all_out = {if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr, stall_if, stall_mem};
    n_checks++;
    if (all_out !== 109'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    int a_bad = 0;
    int w_any = 0;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    run_access(1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
    n_checks++;
    if (obs_done !== 5) begin n_fail++; $display("FAIL fetch_done_cycle: got %0d required 5", obs_done); end
    n_checks++;
    if (obs_data !== 32'h0010_0513) begin n_fail++; $display("FAIL fetch_data: got %h required 00100513", obs_data); end
    for (int k = 0; k < 4; k++) if (k >= obs_a.size() || obs_a[k] !== 32'h100 + 32'(k)) a_bad++;
    foreach (obs_wr[i]) if (obs_wr[i] !== 1'b0) w_any++;
    n_checks++;
    if (a_bad !== 0) begin n_fail++; $display("FAIL fetch_addr_seq: got %0d wrong addresses required 0", a_bad); end
    n_checks++;
    if (w_any !== 0) begin n_fail++; $display("FAIL fetch_no_write: got %0d write cycles required 0", w_any); end
    n_checks++;
    if (obs_stall_bad !== 0) begin n_fail++; $display("FAIL fetch_stall_if: got %0d bad cycles required 0", obs_stall_bad); end
  endtask

  task automatic test_load_word();
    int w_any = 0;
    ram[32'h2000] = 8'hEF; ram[32'h2001] = 8'hBE; ram[32'h2002] = 8'hAD; ram[32'h2003] = 8'hDE;
    run_access(1'b1, 1'b0, 2'b10, 32'h2000, 32'h0);
    n_checks++;
    if (obs_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_word_data: got %h required deadbeef", obs_data); end
    n_checks++;
    if (obs_done !== 5) begin n_fail++; $display("FAIL load_word_done_cycle: got %0d required 5", obs_done); end
    foreach (obs_wr[i]) if (obs_wr[i] !== 1'b0) w_any++;
    n_checks++;
    if (w_any !== 0) begin n_fail++; $display("FAIL load_word_no_write: got %0d required 0", w_any); end
    @(negedge clk);
    n_checks++;
    if (mem_done !== 1'b0) begin n_fail++; $display("FAIL load_word_done_width: got %b required 0", mem_done); end
  endtask

  task automatic test_store_half();
    ram[32'h42] = 8'h5A;
    run_access(1'b1, 1'b1, 2'b01, 32'h40, 32'h1234_ABCD);
    n_checks++;
    if (obs_done !== 2) begin n_fail++; $display("FAIL store_half_done_cycle: got %0d required 2", obs_done); end
    n_checks++;
    if (obs_wr.size() != 3 || {obs_wr[0], obs_wr[1], obs_wr[2]} !== 3'b110) begin
      n_fail++; $display("FAIL store_half_wr_pattern: got %0d cycles observed, required wr 1,1,0", obs_wr.size());
    end
    n_checks++;
    if (wr_log.size() != 2) begin
      n_fail++; $display("FAIL store_half_write_count: got %0d required 2", wr_log.size());
    end else begin
      n_checks++;
      if (wr_log[0] !== {32'h40, 8'hCD} || wr_log[1] !== {32'h41, 8'hAB}) begin
        n_fail++; $display("FAIL store_half_bytes: got %h %h required 00000040cd 00000041ab", wr_log[0], wr_log[1]);
      end
    end
    n_checks++;
    if (ram[32'h42] !== 8'h5A) begin n_fail++; $display("FAIL store_half_no_0x42: got %h required 5a", ram[32'h42]); end
  endtask

  task automatic test_simultaneous();
    int md = -1, idc = -1, bad = 0;
    logic [31:0] mdata = 32'h0, idata = 32'h0, first_a = 32'h0;
    ram[32'h10] = 8'h77;
    ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h10;
    if_req = 1'b1; if_addr = 32'h200;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) first_a = ram_a;
      if (!if_done && stall_if !== 1'b1) bad++;
      if (mem_done) begin md = c; mdata = mem_rdata; mem_req = 1'b0; end
      if (if_done) begin idc = c; idata = if_data; break; end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    n_checks++;
    if (first_a !== 32'h10) begin n_fail++; $display("FAIL simul_mem_first: got ram_a %h required 00000010", first_a); end
    n_checks++;
    if (md !== 2) begin n_fail++; $display("FAIL simul_mem_done_cycle: got %0d required 2", md); end
    n_checks++;
    if (mdata !== 32'h77) begin n_fail++; $display("FAIL simul_mem_data: got %h required 00000077", mdata); end
    n_checks++;
    if (idc <= md || idata !== 32'h4433_2211) begin
      n_fail++; $display("FAIL simul_if_after_mem: got cycle %0d data %h required after %0d data 44332211", idc, idata, md);
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL simul_stall_if: got %0d low cycles required 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [108:0] all_out;
    int pulses = 0;
    ram[32'h300] = 8'hA1; ram[32'h301] = 8'hB2; ram[32'h302] = 8'hC3; ram[32'h303] = 8'hD4;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    if_req = 1'b0;
    #1;
    all_out = {if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr, stall_if, stall_mem};
    n_checks++;
    if (all_out !== 109'd0) begin n_fail++; $display("FAIL reset_mid_outputs: got %h required 0", all_out); end
    repeat (2) begin
      @(negedge clk);
      if (if_done || mem_done) pulses++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (if_done || mem_done) pulses++;
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d pulses required 0", pulses); end
    run_access(1'b0, 1'b0, 2'b10, 32'h300, 32'h0);
    n_checks++;
    if (obs_done !== 5 || obs_data !== 32'hD4C3_B2A1) begin
      n_fail++; $display("FAIL reset_mid_refetch: got cycle %0d data %h required 5 d4c3b2a1", obs_done, obs_data);
    end
  endtask

  task automatic test_io_wait();
    int wr_full = 0, first_wr = -1, dc = -1;
    wr_log.delete();
    @(negedge clk);
    io_full = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h0003_0000; mem_wdata = 32'h0000_00A5;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (ram_wr && io_full) wr_full++;
      if (ram_wr && first_wr < 0) first_wr = c;
      if (c == 2) io_full = 1'b0;
      if (mem_done) begin dc = c; break; end
    end
    mem_req = 1'b0;
    io_full = 1'b0;
    n_checks++;
    if (wr_log.size() != 1 || wr_log[0] !== {32'h0003_0000, 8'hA5}) begin
      n_fail++; $display("FAIL io_store_single_write: got %0d writes required 1 of a5 at 00030000", wr_log.size());
    end
`ifdef MEMCTRL_IO_WAIT_EN
    n_checks++;
    if (wr_full !== 0 || first_wr <= 2) begin
      n_fail++; $display("FAIL io_wait_hold: got %0d writes while full, first at %0d, required 0 and after 2", wr_full, first_wr);
    end
    n_checks++;
    if (dc !== first_wr + 1) begin n_fail++; $display("FAIL io_wait_done: got %0d required %0d", dc, first_wr + 1); end
`else
    n_checks++;
    if (first_wr !== 0 || dc !== 1) begin
      n_fail++; $display("FAIL io_ignored: got write %0d done %0d required 0 and 1", first_wr, dc);
    end
`endif
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      bit          is_mem = 1'($urandom_range(1, 0));
      bit          we     = is_mem & 1'($urandom_range(1, 0));
      logic [1:0]  len    = 2'($urandom_range(3, 0));
      logic [31:0] addr   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : $urandom;
      logic [31:0] wdata  = $urandom;
      int          n      = n_of(is_mem, len);
      logic [31:0] exp_d;
      int          bad    = 0;
      addr[17] = 1'b0;
      for (int k = 0; k < 4; k++) ram[addr + 32'(k)] = 8'($urandom);
      exp_d = exp_read(addr, n);
      run_access(is_mem, we, len, addr, wdata);
      n_checks++;
      if (obs_done !== (we ? n : n + 1)) begin
        n_fail++; $display("FAIL rand%0d_done_cycle: got %0d required %0d", t, obs_done, we ? n : n + 1);
      end
      for (int k = 0; k < n; k++) if (k >= obs_a.size() || obs_a[k] !== addr + 32'(k)) bad++;
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL rand%0d_addr_seq: got %0d wrong required 0", t, bad); end
      if (we) begin
        bad = 0;
        for (int k = 0; k < n; k++) begin
          if (k >= wr_log.size() || wr_log[k] !== {addr + 32'(k), 8'(wdata >> (8 * k))}) bad++;
        end
        n_checks++;
        if (bad !== 0 || wr_log.size() != n) begin
          n_fail++; $display("FAIL rand%0d_store: got %0d writes %0d wrong required %0d", t, wr_log.size(), bad, n);
        end
      end else begin
        n_checks++;
        if (obs_data !== exp_d || wr_log.size() != 0) begin
          n_fail++; $display("FAIL rand%0d_read: got %h writes %0d required %h", t, obs_data, wr_log.size(), exp_d);
        end
      end
      n_checks++;
      if (obs_stall_bad !== 0 || obs_other !== 0) begin
        n_fail++; $display("FAIL rand%0d_stall_other: got %0d %0d required 0 0", t, obs_stall_bad, obs_other);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
    io_full = 1'b0;
    test_reset();
    test_fetch();
    test_load_word();
    test_store_half();
    test_simultaneous();
    test_reset_mid();
    test_io_wait();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
